// File: rtl/bus_codes_pkg.sv
// Bus code map, transfer FSM states and code legality helpers for the shared 32-bit bus.
// Optional macro BUS_SETTLE_EN adds the SETTLE state encoding.
package bus_codes_pkg;

    localparam int CODE_W     = 5;
    localparam int CODE_SPACE = 32;

    localparam logic [4:0] CODE_R0      = 5'd0;
    localparam logic [4:0] CODE_R1      = 5'd1;
    localparam logic [4:0] CODE_R2      = 5'd2;
    localparam logic [4:0] CODE_R3      = 5'd3;
    localparam logic [4:0] CODE_R4      = 5'd4;
    localparam logic [4:0] CODE_R5      = 5'd5;
    localparam logic [4:0] CODE_R6      = 5'd6;
    localparam logic [4:0] CODE_R7      = 5'd7;
    localparam logic [4:0] CODE_R8      = 5'd8;
    localparam logic [4:0] CODE_R9      = 5'd9;
    localparam logic [4:0] CODE_R10     = 5'd10;
    localparam logic [4:0] CODE_R11     = 5'd11;
    localparam logic [4:0] CODE_R12     = 5'd12;
    localparam logic [4:0] CODE_R13     = 5'd13;
    localparam logic [4:0] CODE_R14     = 5'd14;
    localparam logic [4:0] CODE_R15     = 5'd15;
    localparam logic [4:0] CODE_HI      = 5'd16;
    localparam logic [4:0] CODE_LO      = 5'd17;
    localparam logic [4:0] CODE_ZHIGH   = 5'd18;
    localparam logic [4:0] CODE_ZLOW    = 5'd19;
    localparam logic [4:0] CODE_PC      = 5'd20;
    localparam logic [4:0] CODE_MDR     = 5'd21;
    localparam logic [4:0] CODE_IN_PORT = 5'd22;
    localparam logic [4:0] CODE_C       = 5'd23;
    localparam logic [4:0] CODE_MAR     = 5'd24;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        DRIVE  = 3'd1,
`ifdef BUS_SETTLE_EN
        SETTLE = 3'd2,
`endif
        LATCH  = 3'd3,
        ERR    = 3'd4
    } xfer_state_t;

    // Everything up to C may drive; MAR and unassigned codes never do.
    function automatic logic src_legal(input logic [4:0] code);
        return (code <= CODE_C);
    endfunction

    // Z is ALU-loaded, C is constant and In_Port is external, so none accept the bus.
    function automatic logic dst_legal(input logic [4:0] code);
        return (code <= CODE_LO) || (code == CODE_PC) ||
               (code == CODE_MDR) || (code == CODE_MAR);
    endfunction

endpackage

// File: rtl/onehot_decoder_5to32.sv
// 5-bit code to 32-bit one-hot decoder; all zeros while en is low.
module onehot_decoder_5to32
    import bus_codes_pkg::*;
(
    input  logic                  en,
    input  logic [CODE_W-1:0]     code,
    output logic [CODE_SPACE-1:0] onehot
);

    always_comb begin
        onehot = '0;
        if (en) begin
            onehot[code] = 1'b1;
        end
    end

endmodule

// File: rtl/bus_transfer_decoder.sv
// Sequenced bus-transfer controller: decodes captured source/destination codes into
// one-hot out/in enables over DRIVE(/SETTLE)/LATCH. Optional macro: BUS_SETTLE_EN.
module bus_transfer_decoder
    import bus_codes_pkg::*;
#(
    parameter int NUM_CODES = 32
) (
    input  logic                 clk,
    input  logic                 clr_n,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [4:0]           src_code,
    input  logic [4:0]           dst_code,
    output logic [NUM_CODES-1:0] out_en,
    output logic [NUM_CODES-1:0] in_en,
    output logic                 busy,
    output logic                 done,
    output logic                 err,
    output xfer_state_t          dbg_state_o
);

    // Handshake: a request is taken on any rising edge where req_valid && req_ready;
    // req_ready is high only in IDLE, so the requester holds req_valid until then.
    xfer_state_t state_q;
    logic [4:0]  src_q;
    logic [4:0]  dst_q;
    logic        src_drive;
    logic        dst_latch;

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state_q <= IDLE;
            src_q   <= '0;
            dst_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        src_q   <= src_code;
                        dst_q   <= dst_code;
                        state_q <= (src_legal(src_code) && dst_legal(dst_code)) ? DRIVE : ERR;
                    end
                end
`ifdef BUS_SETTLE_EN
                DRIVE:   state_q <= SETTLE;
                SETTLE:  state_q <= LATCH;
`else
                DRIVE:   state_q <= LATCH;
`endif
                LATCH:   state_q <= IDLE;
                ERR:     state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    // Enables are decoded only from registered state and codes, so reset clears them at once.
`ifdef BUS_SETTLE_EN
    assign src_drive = (state_q == DRIVE) || (state_q == SETTLE) || (state_q == LATCH);
`else
    assign src_drive = (state_q == DRIVE) || (state_q == LATCH);
`endif
    assign dst_latch = (state_q == LATCH);

    onehot_decoder_5to32 u_src_dec (
        .en     (src_drive),
        .code   (src_q),
        .onehot (out_en)
    );

    onehot_decoder_5to32 u_dst_dec (
        .en     (dst_latch),
        .code   (dst_q),
        .onehot (in_en)
    );

    assign req_ready   = (state_q == IDLE);
    assign busy        = (state_q != IDLE);
    assign done        = (state_q == LATCH);
    assign err         = (state_q == ERR);
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_bus_transfer_decoder.sv
// Directed self-checking bench for bus_transfer_decoder (default and BUS_SETTLE_EN builds).
module tb_bus_transfer_decoder;
    import bus_codes_pkg::*;

`ifdef BUS_SETTLE_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 2;
`endif

    logic        clk;
    logic        clr_n;
    logic        req_valid;
    logic        req_ready;
    logic [4:0]  src_code;
    logic [4:0]  dst_code;
    logic [31:0] out_en;
    logic [31:0] in_en;
    logic        busy;
    logic        done;
    logic        err;
    xfer_state_t dbg_state;

    int vectors;
    int miscompares;

    bus_transfer_decoder #(.NUM_CODES(32)) dut (
        .clk         (clk),
        .clr_n       (clr_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .src_code    (src_code),
        .dst_code    (dst_code),
        .out_en      (out_en),
        .in_en       (in_en),
        .busy        (busy),
        .done        (done),
        .err         (err),
        .dbg_state_o (dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Invariants checked every cycle: at most one enable bit each, done and err exclusive.
    always @(negedge clk) begin
        vectors++;
        if ($countones(out_en) > 1 || $countones(in_en) > 1 || (done && err)) begin
            miscompares++;
            $display("FAIL invariant: out_en=%h in_en=%h done=%b err=%b, required one-hot/zero and not both",
                     out_en, in_en, done, err);
        end
    end

    // Presents a request just after a rising edge; the following edge accepts it (cycle 0).
    task automatic issue(input logic [4:0] s, input logic [4:0] d);
        @(posedge clk); #1;
        req_valid = 1'b1;
        src_code  = s;
        dst_code  = d;
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    task automatic test_reset();
        #1;
        vectors++;
        if (out_en !== 32'h0 || in_en !== 32'h0 || done !== 1'b0 || err !== 1'b0 ||
            busy !== 1'b0 || req_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_hold: out_en=%h in_en=%h done=%b err=%b busy=%b ready=%b, required 0/0/0/0/0/1",
                     out_en, in_en, done, err, busy, req_ready);
        end
        @(posedge clk); #1;
        clr_n = 1'b1;
        @(negedge clk);
        vectors++;
        if (dbg_state !== IDLE || req_ready !== 1'b1 || busy !== 1'b0 || out_en !== 32'h0) begin
            miscompares++;
            $display("FAIL reset_release: state=%0d ready=%b busy=%b out_en=%h, required IDLE/1/0/0",
                     dbg_state, req_ready, busy, out_en);
        end
    endtask

    task automatic test_valid_transfer(input logic [4:0] s, input logic [4:0] d,
                                       input logic [31:0] exp_out, input logic [31:0] exp_in);
        issue(s, d);
        for (int c = 1; c < LAT; c++) begin
            @(negedge clk);
            vectors++;
            if (out_en !== exp_out || in_en !== 32'h0 || done !== 1'b0 || busy !== 1'b1 || req_ready !== 1'b0) begin
                miscompares++;
                $display("FAIL xfer_drive c%0d: out_en=%h in_en=%h done=%b busy=%b ready=%b, required %h/0/0/1/0",
                         c, out_en, in_en, done, busy, req_ready, exp_out);
            end
        end
        @(negedge clk);
        vectors++;
        if (out_en !== exp_out || in_en !== exp_in || done !== 1'b1 || err !== 1'b0) begin
            miscompares++;
            $display("FAIL xfer_latch: out_en=%h in_en=%h done=%b err=%b, required %h/%h/1/0",
                     out_en, in_en, done, err, exp_out, exp_in);
        end
        @(negedge clk);
        vectors++;
        if (req_ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || out_en !== 32'h0 || in_en !== 32'h0) begin
            miscompares++;
            $display("FAIL xfer_idle: ready=%b busy=%b done=%b out_en=%h in_en=%h, required 1/0/0/0/0",
                     req_ready, busy, done, out_en, in_en);
        end
    endtask

    task automatic test_illegal(input logic [4:0] s, input logic [4:0] d);
        issue(s, d);
        @(negedge clk);
        vectors++;
        if (err !== 1'b1 || done !== 1'b0 || out_en !== 32'h0 || in_en !== 32'h0 || busy !== 1'b1) begin
            miscompares++;
            $display("FAIL illegal_err src=%0d dst=%0d: err=%b done=%b out_en=%h in_en=%h busy=%b, required 1/0/0/0/1",
                     s, d, err, done, out_en, in_en, busy);
        end
        @(negedge clk);
        vectors++;
        if (req_ready !== 1'b1 || err !== 1'b0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL illegal_ready src=%0d dst=%0d: ready=%b err=%b busy=%b, required 1/0/0",
                     s, d, req_ready, err, busy);
        end
    endtask

    task automatic test_back_to_back();
        @(posedge clk); #1;
        req_valid = 1'b1;
        src_code  = 5'd1;
        dst_code  = 5'd2;
        @(posedge clk); #1;
        src_code  = 5'd21;
        dst_code  = 5'd24;
        for (int c = 1; c <= LAT; c++) begin
            @(negedge clk);
            vectors++;
            if (req_ready !== 1'b0 || out_en !== 32'h0000_0002) begin
                miscompares++;
                $display("FAIL b2b_first c%0d: ready=%b out_en=%h, required 0/00000002", c, req_ready, out_en);
            end
        end
        vectors++;
        if (in_en !== 32'h0000_0004 || done !== 1'b1) begin
            miscompares++;
            $display("FAIL b2b_first_latch: in_en=%h done=%b, required 00000004/1", in_en, done);
        end
        @(negedge clk);
        vectors++;
        if (req_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL b2b_second_ready: ready=%b, required 1", req_ready);
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
        for (int c = 1; c < LAT; c++) begin
            @(negedge clk);
            vectors++;
            if (out_en !== 32'h0020_0000 || in_en !== 32'h0 || busy !== 1'b1) begin
                miscompares++;
                $display("FAIL b2b_second_drive c%0d: out_en=%h in_en=%h busy=%b, required 00200000/0/1",
                         c, out_en, in_en, busy);
            end
        end
        @(negedge clk);
        vectors++;
        if (in_en !== 32'h0100_0000 || out_en !== 32'h0020_0000 || done !== 1'b1) begin
            miscompares++;
            $display("FAIL b2b_second_latch: in_en=%h out_en=%h done=%b, required 01000000/00200000/1",
                     in_en, out_en, done);
        end
        @(negedge clk);
    endtask

    task automatic test_input_change();
        issue(5'd7, 5'd9);
        src_code = 5'd30;
        dst_code = 5'd1;
        for (int c = 1; c < LAT; c++) begin
            @(negedge clk);
            vectors++;
            if (out_en !== 32'h0000_0080 || in_en !== 32'h0) begin
                miscompares++;
                $display("FAIL hold_drive c%0d: out_en=%h in_en=%h, required 00000080/0", c, out_en, in_en);
            end
            src_code = 5'd12;
            dst_code = 5'd13;
        end
        @(negedge clk);
        vectors++;
        if (out_en !== 32'h0000_0080 || in_en !== 32'h0000_0200 || done !== 1'b1) begin
            miscompares++;
            $display("FAIL hold_latch: out_en=%h in_en=%h done=%b, required 00000080/00000200/1",
                     out_en, in_en, done);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_transfer();
        issue(5'd4, 5'd6);
        repeat (LAT) @(negedge clk);
        vectors++;
        if (done !== 1'b1 || in_en !== 32'h0000_0040) begin
            miscompares++;
            $display("FAIL rst_pre_latch: done=%b in_en=%h, required 1/00000040", done, in_en);
        end
        #2;
        clr_n = 1'b0;
        #1;
        vectors++;
        if (out_en !== 32'h0 || in_en !== 32'h0 || done !== 1'b0 || err !== 1'b0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL rst_async: out_en=%h in_en=%h done=%b err=%b busy=%b, required all 0",
                     out_en, in_en, done, err, busy);
        end
        @(posedge clk); #1;
        clr_n = 1'b1;
        repeat (2) begin
            @(negedge clk);
            vectors++;
            if (req_ready !== 1'b1 || done !== 1'b0 || err !== 1'b0 || out_en !== 32'h0) begin
                miscompares++;
                $display("FAIL rst_after: ready=%b done=%b err=%b out_en=%h, required 1/0/0/0",
                         req_ready, done, err, out_en);
            end
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        clr_n       = 1'b0;
        req_valid   = 1'b0;
        src_code    = 5'd0;
        dst_code    = 5'd0;

        test_reset();
        test_valid_transfer(5'd3, 5'd20, 32'h0000_0008, 32'h0010_0000);
        test_illegal(5'd24, 5'd5);
        test_illegal(5'd2, 5'd22);
        test_illegal(5'd31, 5'd18);
        test_valid_transfer(5'd23, 5'd24, 32'h0080_0000, 32'h0100_0000);
        test_valid_transfer(5'd16, 5'd17, 32'h0001_0000, 32'h0002_0000);
        test_valid_transfer(5'd9, 5'd9, 32'h0000_0200, 32'h0000_0200);
        test_back_to_back();
        test_input_change();
        test_reset_mid_transfer();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
